// File: rtl/pool_out_packer_if.sv
// Element-in / beat-out streaming bundle for the pooling output packer.
interface pool_out_packer_if #(
  parameter int unsigned BUS_W = 128
);
  logic [31:0]      in_data;
  logic             in_valid;
  logic             in_ready;
  logic [BUS_W-1:0] out_data;
  logic             out_valid;
  logic             out_last;
  logic             out_ready;

  // Packer side: consumes elements, produces beats.
  modport master (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last
  );

  // Environment side: produces elements, consumes beats.
  modport slave (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );
endinterface

// File: rtl/pool_out_packer.sv
// Requantises signed 32-bit pooled results and packs them LSB-first into bus beats.
module pool_out_packer #(
  parameter int unsigned BUS_W = 128,
  parameter int unsigned CNT_W = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           cfg_elem_bits,
  input  logic [4:0]           cfg_shift,
  input  logic [CNT_W-1:0]     cfg_total,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  pool_out_packer_if.master    bus
);

  localparam int unsigned SLOT_W = $clog2(BUS_W / 2);

  typedef enum logic [1:0] {S_IDLE, S_PACK, S_DRAIN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [2:0]         eb_log_q, eb_log_d;
  logic [4:0]         shift_q, shift_d;
  logic [CNT_W-1:0]   total_q, total_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SLOT_W-1:0]  slot_q, slot_d;
  logic [BUS_W-1:0]   acc_q, acc_d;
  logic [BUS_W-1:0]   out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               in_ready_c, accept_c, last_elem_c, beat_full_c;
  logic [SLOT_W-1:0]  slot_max_c;
  logic [5:0]         elem_bits_c;
  logic signed [32:0] x_ext_c, rnd_c, r_c, sat_max_c, sat_min_c;
  logic [31:0]        q_c, mask_c;
  logic [BUS_W-1:0]   merged_c;
  logic [2:0]         cfg_log_c;
  logic               cfg_ok_c;

  // Handshake qualifiers and beat-boundary detection.
  always_comb begin
    in_ready_c  = (state_q == S_PACK) && (!out_valid_q || bus.out_ready);
    accept_c    = in_ready_c && bus.in_valid;
    last_elem_c = (cnt_q == total_q - CNT_W'(1));
    slot_max_c  = SLOT_W'((BUS_W >> eb_log_q) - 1);
    beat_full_c = (slot_q == slot_max_c);
  end

  // Supported element widths decode to log2; anything else is flagged.
  always_comb begin
    cfg_log_c = 3'd0;
    cfg_ok_c  = 1'b1;
    case (cfg_elem_bits)
      8'd2:    cfg_log_c = 3'd1;
      8'd4:    cfg_log_c = 3'd2;
      8'd8:    cfg_log_c = 3'd3;
      8'd16:   cfg_log_c = 3'd4;
      8'd32:   cfg_log_c = 3'd5;
      default: cfg_ok_c  = 1'b0;
    endcase
  end

  // Rounding shift, then saturation or 2-bit ternary-like encoding, then slot placement.
  always_comb begin
    elem_bits_c = 6'(6'd1 << eb_log_q);
    x_ext_c     = {bus.in_data[31], bus.in_data};
    rnd_c       = (shift_q == 5'd0) ? 33'sd0 : (33'sd1 <<< (shift_q - 5'd1));
    r_c         = (x_ext_c + rnd_c) >>> shift_q;
    sat_max_c   = (33'sd1 <<< (elem_bits_c - 6'd1)) - 33'sd1;
    sat_min_c   = ~sat_max_c;
    q_c         = r_c[31:0];
    if (eb_log_q == 3'd1) begin
      if (r_c < -33'sd1)      q_c = 32'd0;
      else if (r_c < 33'sd1)  q_c = 32'd1;
      else if (r_c < 33'sd3)  q_c = 32'd2;
      else                    q_c = 32'd3;
    end else if (r_c > sat_max_c) begin
      q_c = sat_max_c[31:0];
    end else if (r_c < sat_min_c) begin
      q_c = sat_min_c[31:0];
    end
    mask_c   = (eb_log_q == 3'd5) ? 32'hFFFF_FFFF : ((32'd1 << elem_bits_c) - 32'd1);
    merged_c = acc_q | (BUS_W'(q_c & mask_c) << (32'(slot_q) << eb_log_q));
  end

  // Next-state and next-output logic for the job sequencer and beat register.
  always_comb begin
    state_d     = state_q;
    eb_log_d    = eb_log_q;
    shift_d     = shift_q;
    total_d     = total_q;
    cnt_d       = cnt_q;
    slot_d      = slot_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d   = 1'b1;
          eb_log_d = cfg_log_c;
          shift_d  = cfg_shift;
          total_d  = cfg_total;
          cnt_d    = '0;
          slot_d   = '0;
          acc_d    = '0;
          if (!cfg_ok_c) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else if (cfg_total == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_PACK;
          end
        end
      end
      S_PACK: begin
        if (accept_c) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (beat_full_c || last_elem_c) begin
            out_data_d  = merged_c;
            out_valid_d = 1'b1;
            out_last_d  = last_elem_c;
            acc_d       = '0;
            slot_d      = '0;
          end else begin
            acc_d  = merged_c;
            slot_d = slot_q + SLOT_W'(1);
          end
          if (last_elem_c) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (out_valid_q && out_last_q && bus.out_ready) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      eb_log_q    <= '0;
      shift_q     <= '0;
      total_q     <= '0;
      cnt_q       <= '0;
      slot_q      <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      eb_log_q    <= eb_log_d;
      shift_q     <= shift_d;
      total_q     <= total_d;
      cnt_q       <= cnt_d;
      slot_q      <= slot_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign bus.in_ready  = in_ready_c;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;

endmodule
